// File: rtl/dct_cmp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dct_cmp_pkg                                                  |
// | Description : Shared defaults, FSM state encoding and helper function for  |
// |               the DCT coefficient threshold / run-length encoder.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dct_cmp_pkg;

    // Default geometry of one coefficient block.
    localparam int c_DATA_W = 12;
    localparam int c_N_COEF = 8;
    localparam int c_CNT_W  = 8;

    // Encoder FSM states.
    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_SCAN  = 2'd1;
    localparam state_t c_ST_FLUSH = 2'd2;

    // Largest run length a CNT_W-bit counter can report.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coef_threshold.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coef_threshold                                               |
// | Description : Symmetric hard threshold of one signed coefficient. Values   |
// |               inside [-thr, +thr] become zero, others pass unchanged.      |
// | Ports       : i_coef  - signed coefficient (DATA_W)                        |
// |               i_thr   - unsigned threshold magnitude (DATA_W-1)            |
// |               o_coef  - thresholded coefficient (DATA_W)                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module coef_threshold
    import dct_cmp_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic signed [DATA_W-1:0] i_coef,
    input  logic        [DATA_W-2:0] i_thr,
    output logic signed [DATA_W-1:0] o_coef
);

    // One extra bit so that -thr and the most-negative coefficient are both
    // representable without wrap-around.
    logic signed [DATA_W:0] w_x;
    logic signed [DATA_W:0] w_pos;
    logic signed [DATA_W:0] w_neg;
    logic                   w_inside;

    assign w_x      = {i_coef[DATA_W-1], i_coef};
    assign w_pos    = {2'b00, i_thr};
    assign w_neg    = -w_pos;
    assign w_inside = (w_x >= w_neg) && (w_x <= w_pos);
    assign o_coef   = w_inside ? '0 : i_coef;

endmodule
`default_nettype wire

// File: rtl/dct_coef_rle_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dct_coef_rle_encoder                                         |
// | Description : Accepts a block of N_COEF signed DCT coefficients, scans     |
// |               them from index 0 upward through a programmable hard         |
// |               threshold and emits (value, run-length) pairs, the final     |
// |               pair of each block flagged with out_last.                    |
// | Ports       : clk, rst_n           - clock, sync active-low reset          |
// |               in_valid/in_ready    - block handshake                       |
// |               coef_in              - packed block, coef k at k*DATA_W      |
// |               thr                  - threshold magnitude, taken on accept  |
// |               out_valid/out_ready  - pair handshake                        |
// |               out_value/out_count  - run value and run length             |
// |               out_last             - final pair of the block               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dct_coef_rle_encoder
    import dct_cmp_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int N_COEF = c_N_COEF,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_COEF*DATA_W-1:0]   coef_in,
    input  logic [DATA_W-2:0]          thr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_value,
    output logic [CNT_W-1:0]           out_count,
    output logic                       out_last
);

    localparam int                 c_IDX_W    = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_COEF - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_coef [N_COEF];
    logic [DATA_W-2:0]        r_thr;
    logic [c_IDX_W-1:0]       r_idx;
    logic signed [DATA_W-1:0] r_run_val;
    logic [CNT_W-1:0]         r_run_cnt;
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_out_value;
    logic [CNT_W-1:0]         r_out_count;
    logic                     r_out_last;

    logic                     w_accept;
    logic                     w_adv;
    logic                     w_extend;
    logic                     w_emit_scan;
    logic                     w_emit_flush;
    logic signed [DATA_W-1:0] w_y;

    coef_threshold #(
        .DATA_W (DATA_W)
    ) u_thr (
        .i_coef (r_coef[r_idx]),
        .i_thr  (r_thr),
        .o_coef (w_y)
    );

    // in_ready is gated by rst_n so no block is taken during a reset cycle.
    assign in_ready = rst_n && (r_state == c_ST_IDLE);
    assign w_accept = in_valid && in_ready;

    // The pair register can take a new entry when empty or draining now;
    // SCAN and FLUSH only move when that is true, so no pair is ever lost.
    assign w_adv = !r_out_valid || out_ready;

    // A saturated run is closed even if the next value matches it.
    assign w_extend     = (w_y == r_run_val) && (r_run_cnt < c_CNT_MAX);
    assign w_emit_scan  = (r_state == c_ST_SCAN) && w_adv && (r_idx != '0) && !w_extend;
    assign w_emit_flush = (r_state == c_ST_FLUSH) && w_adv;

    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_thr       <= '0;
            r_idx       <= '0;
            r_run_val   <= '0;
            r_run_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_value <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
            for (int k = 0; k < N_COEF; k++) begin
                r_coef[k] <= '0;
            end
        end else begin
            // Output pair register
            if (w_emit_scan || w_emit_flush) begin
                r_out_valid <= 1'b1;
                r_out_value <= r_run_val;
                r_out_count <= r_run_cnt;
                r_out_last  <= w_emit_flush;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < N_COEF; k++) begin
                            r_coef[k] <= coef_in[k*DATA_W +: DATA_W];
                        end
                        r_thr   <= thr;
                        r_idx   <= '0;
                        r_state <= c_ST_SCAN;
                    end
                end
                c_ST_SCAN: begin
                    if (w_adv) begin
                        // Index 0 always opens a fresh run so runs never
                        // merge across blocks.
                        if ((r_idx == '0) || !w_extend) begin
                            r_run_val <= w_y;
                            r_run_cnt <= c_CNT_ONE;
                        end else begin
                            r_run_cnt <= r_run_cnt + c_CNT_ONE;
                        end
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_FLUSH;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                c_ST_FLUSH: begin
                    if (w_adv) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_coef_rle_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dct_coef_rle_encoder                                      |
// | Description : Directed self-checking bench for dct_coef_rle_encoder.       |
// |               u_dut uses default geometry, u_dut_sat a 3-bit run counter.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dct_coef_rle_encoder;

    localparam int c_DW  = 12;
    localparam int c_N   = 8;
    localparam int c_CW  = 8;
    localparam int c_CW2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    in_valid,  in_ready,  out_valid,  out_ready,  out_last;
    logic [c_N*c_DW-1:0]     coef_in;
    logic [c_DW-2:0]         thr;
    logic signed [c_DW-1:0]  out_value;
    logic [c_CW-1:0]         out_count;

    logic                    in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [c_N*c_DW-1:0]     coef_in2;
    logic [c_DW-2:0]         thr2;
    logic signed [c_DW-1:0]  out_value2;
    logic [c_CW2-1:0]        out_count2;

    dct_coef_rle_encoder #(.DATA_W(c_DW), .N_COEF(c_N), .CNT_W(c_CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .coef_in(coef_in), .thr(thr), .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_count(out_count), .out_last(out_last)
    );

    dct_coef_rle_encoder #(.DATA_W(c_DW), .N_COEF(c_N), .CNT_W(c_CW2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .coef_in(coef_in2), .thr(thr2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_value(out_value2), .out_count(out_count2), .out_last(out_last2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pair = {value[11:0], count[7:0], last}
    function automatic logic [20:0] pk(input int v, input int c, input bit l);
        logic [20:0] r;
        r = {12'(v), 8'(c), l};
        return r;
    endfunction

    function automatic logic [c_N*c_DW-1:0] mkblk(input int c0, input int c1, input int c2,
                                                  input int c3, input int c4, input int c5,
                                                  input int c6, input int c7);
        logic [c_N*c_DW-1:0] r;
        int c[8];
        c = '{c0, c1, c2, c3, c4, c5, c6, c7};
        for (int k = 0; k < c_N; k++) r[k*c_DW +: c_DW] = 12'(c[k]);
        return r;
    endfunction

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    int          ncyc = 0;
    int          last_cnt = 0;
    int          last_cnt2 = 0;
    int          rdy_rise = -1;
    logic        prev_rdy = 1'b0;
    logic [20:0] got_q[$];
    logic [20:0] got2_q[$];
    logic [20:0] exp_q[$];
    int          tq[$];
    int          acq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_value, out_count, out_last});
                tq.push_back(ncyc);
                if (out_last) last_cnt++;
            end
            if (in_valid && in_ready) acq.push_back(ncyc);
            if (in_ready && !prev_rdy) rdy_rise = ncyc;
            if (out_valid2 && out_ready2) begin
                got2_q.push_back({out_value2, 5'b0, out_count2, out_last2});
                if (out_last2) last_cnt2++;
            end
        end
        prev_rdy = in_ready;
        ncyc++;
    end

    task automatic clear_all();
        got_q.delete(); got2_q.delete(); exp_q.delete(); tq.delete(); acq.delete();
        last_cnt = 0; last_cnt2 = 0;
    endtask

    task automatic wait_accept(input string tag, input bit sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sel ? in_ready2 : in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " accept"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_lasts(input string tag, input bit sel, input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if ((sel ? last_cnt2 : last_cnt) >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " done"}, 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_pairs(input string tag, input bit sel);
        logic [20:0] g[$];
        if (sel) g = got2_q;
        else     g = got_q;
        check({tag, " npairs"}, 32'(g.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < g.size()) check($sformatf("%s pair%0d", tag, i), 32'(g[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic push_s1();
        exp_q.push_back(pk(20, 1, 0));
        exp_q.push_back(pk(0, 4, 0));
        exp_q.push_back(pk(7, 2, 0));
        exp_q.push_back(pk(-6, 1, 1));
    endtask

    task automatic push_s2();
        exp_q.push_back(pk(0, 2, 0));
        exp_q.push_back(pk(6, 1, 0));
        exp_q.push_back(pk(-6, 1, 0));
        exp_q.push_back(pk(6, 2, 0));
        exp_q.push_back(pk(0, 2, 1));
    endtask

    logic [c_N*c_DW-1:0] blk1, blk2;
    logic [20:0]         hold;
    bit                  seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        blk1 = mkblk(20, 3, -4, 0, 0, 7, 7, -6);
        blk2 = mkblk(5, -5, 6, -6, 6, 6, 0, -1);
        rst_n = 1'b0; in_valid = 1'b0; coef_in = '0; thr = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; coef_in2 = '0; thr2 = '0; out_ready2 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready",  32'(in_ready),  32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_value", 32'(out_value), 32'd0);
        check("rst out_count", 32'(out_count), 32'd0);
        check("rst out_last",  32'(out_last),  32'd0);
        check("rst in_ready2", 32'(in_ready2), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 1: basic encode, latency, thr change after accept ignored
        clear_all();
        coef_in = blk1; thr = 11'd5; in_valid = 1'b1;
        wait_accept("s1", 1'b0);
        in_valid = 1'b0; thr = '0; coef_in = mkblk(1, 2, 3, 4, 5, 6, 7, 8);
        wait_lasts("s1", 1'b0, 1);
        push_s1();
        check_pairs("s1", 1'b0);
        if (tq.size() == 4 && acq.size() == 1) begin
            check("s1 first lat", 32'(tq[0] - acq[0]), 32'd3);
            check("s1 last lat",  32'(tq[3] - acq[0]), 32'd10);
            check("s1 rdy lat",   32'(rdy_rise - acq[0]), 32'd10);
        end

        // 2: threshold boundary
        clear_all();
        coef_in = blk2; thr = 11'd5; in_valid = 1'b1;
        wait_accept("s2", 1'b0);
        in_valid = 1'b0;
        wait_lasts("s2", 1'b0, 1);
        push_s2();
        check_pairs("s2", 1'b0);

        // 3: saturation with a 3-bit counter, and a full zero run
        clear_all();
        coef_in2 = mkblk(9, 9, 9, 9, 9, 9, 9, 9); thr2 = '0; in_valid2 = 1'b1;
        wait_accept("s3a", 1'b1);
        in_valid2 = 1'b0;
        wait_lasts("s3a", 1'b1, 1);
        exp_q.push_back(pk(9, 7, 0));
        exp_q.push_back(pk(9, 1, 1));
        check_pairs("s3a", 1'b1);

        clear_all();
        coef_in = '0; thr = '0; in_valid = 1'b1;
        wait_accept("s3b", 1'b0);
        in_valid = 1'b0;
        wait_lasts("s3b", 1'b0, 1);
        exp_q.push_back(pk(0, 8, 1));
        check_pairs("s3b", 1'b0);

        // 4: backpressure for 5 cycles after first out_valid, in_valid held
        clear_all();
        coef_in = blk1; thr = 11'd5; in_valid = 1'b1;
        fork
            begin
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) seen = 1'b1;
                end
                check("s4 first valid", 32'(seen), 32'd1);
                if (seen) begin
                    hold = {out_value, out_count, out_last};
                    out_ready = 1'b0;
                    for (int j = 0; j < 5; j++) begin
                        @(negedge clk);
                        check("s4 hold", {10'd0, out_valid, hold},
                              {10'd0, 1'b1, out_value, out_count, out_last});
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            end
        join_none
        wait_accept("s4 b1", 1'b0);
        wait_accept("s4 b2", 1'b0);
        in_valid = 1'b0;
        wait_lasts("s4", 1'b0, 2);
        push_s1();
        push_s1();
        check_pairs("s4", 1'b0);
        check("s4 n accepts", 32'(acq.size()), 32'd2);
        if (tq.size() >= 4 && acq.size() == 2) begin
            check("s4 last lat",   32'(tq[3] - acq[0]), 32'd15);
            check("s4 reaccept",   32'(acq[1] - acq[0]), 32'd15);
        end

        // 5: back-to-back, block 2 starts with block 1's last value
        clear_all();
        coef_in = blk1; thr = 11'd5; in_valid = 1'b1;
        wait_accept("s5 b1", 1'b0);
        coef_in = mkblk(-6, -6, -6, 9, 9, 9, 9, 9);
        wait_accept("s5 b2", 1'b0);
        in_valid = 1'b0;
        wait_lasts("s5", 1'b0, 2);
        push_s1();
        exp_q.push_back(pk(-6, 3, 0));
        exp_q.push_back(pk(9, 5, 1));
        check_pairs("s5", 1'b0);
        if (acq.size() == 2) check("s5 reaccept", 32'(acq[1] - acq[0]), 32'd10);

        // 6: reset mid-block, then a clean block
        clear_all();
        coef_in = blk2; thr = 11'd5; in_valid = 1'b1;
        wait_accept("s6 abort", 1'b0);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        check("s6 rst in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("s6 out_valid", 32'(out_valid), 32'd0);
        check("s6 in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        clear_all();
        coef_in = blk2; thr = 11'd5; in_valid = 1'b1;
        wait_accept("s6", 1'b0);
        in_valid = 1'b0;
        wait_lasts("s6", 1'b0, 1);
        push_s2();
        check_pairs("s6", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
